// File: rtl/dll_pkg.sv
// Shared DLL encodings: DLCMSM link state and TX arbiter FSM state.
package dll_pkg;

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'b00,
    DL_INIT     = 2'b01,
    DL_ACTIVE   = 2'b10
  } dlcm_state_t;

  typedef enum logic {
    ARB      = 1'b0,
    TLP_BUSY = 1'b1
  } tx_arb_state_t;

endpackage

// File: rtl/dll_tx_arbiter_if.sv
// TLP/DLLP source handshakes and the PIPE TX beat for the DLL TX arbiter.
interface dll_tx_arbiter_if #(
  parameter int PIPE_DATA_WIDTH = 256
);
  logic [1:0]                 dlcm_state_i;
  logic                       tlp_valid_i;
  logic [PIPE_DATA_WIDTH-1:0] tlp_data_i;
  logic                       tlp_last_i;
  logic                       tlp_ready_o;
  logic                       dllp_valid_i;
  logic [PIPE_DATA_WIDTH-1:0] dllp_data_i;
  logic                       dllp_ready_o;
  logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o;
  logic                       pipe_txvalid_o;

  modport master (
    output dlcm_state_i, tlp_valid_i, tlp_data_i, tlp_last_i, dllp_valid_i, dllp_data_i,
    input  tlp_ready_o, dllp_ready_o, pipe_txdata_o, pipe_txvalid_o
  );

  modport slave (
    input  dlcm_state_i, tlp_valid_i, tlp_data_i, tlp_last_i, dllp_valid_i, dllp_data_i,
    output tlp_ready_o, dllp_ready_o, pipe_txdata_o, pipe_txvalid_o
  );
endinterface

// File: rtl/dll_tx_arbiter.sv
// DLL TX arbiter: packet-boundary TLP/DLLP scheduling onto PIPE TX, gated by DLCMSM.
// Optional DLL_TX_ARB_STATS_EN adds beat/DLLP/starvation counters.
//
// state    | meaning
// ARB      | at a packet boundary, choosing the next source
// TLP_BUSY | inside a multi-beat TLP, only TLP beats pass
module dll_tx_arbiter
  import dll_pkg::*;
#(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int MAX_DLLP_BURST  = 4
) (
  input logic             sclk,
  input logic             srst_n,
  dll_tx_arbiter_if.slave bus
`ifdef DLL_TX_ARB_STATS_EN
  ,
  output logic [31:0]     stat_tlp_beats_o,
  output logic [31:0]     stat_dllp_cnt_o,
  output logic [31:0]     stat_starve_o
`endif
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DLLP_BURST);

  tx_arb_state_t              state;
  logic [3:0]                 burst_cnt;
  logic                       tlp_ok;
  logic                       dllp_ok;
  logic                       tlp_req;
  logic                       dllp_req;
  logic                       dllp_gnt;
  logic                       tlp_gnt;
  logic                       tlp_rdy;
  logic                       tlp_take;
  logic                       dllp_take;
  logic [PIPE_DATA_WIDTH-1:0] tx_data_d;

  always_comb begin
    tlp_ok    = (bus.dlcm_state_i == DL_ACTIVE);
    dllp_ok   = (bus.dlcm_state_i == DL_INIT) || (bus.dlcm_state_i == DL_ACTIVE);
    tlp_req   = bus.tlp_valid_i && tlp_ok;
    dllp_req  = bus.dllp_valid_i && dllp_ok;
    // DLLPs win unless the burst budget is spent while a TLP is waiting
    dllp_gnt  = srst_n && (state == ARB) && dllp_req &&
                ((burst_cnt < BURST_MAX) || !tlp_req);
    tlp_gnt   = srst_n && (state == ARB) && !dllp_gnt && tlp_req;
    tlp_rdy   = tlp_gnt || (srst_n && (state == TLP_BUSY));
    tlp_take  = tlp_rdy && bus.tlp_valid_i;
    dllp_take = dllp_gnt;
    tx_data_d = dllp_take ? bus.dllp_data_i : bus.tlp_data_i;
  end

  assign bus.tlp_ready_o  = tlp_rdy;
  assign bus.dllp_ready_o = dllp_gnt;

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      state              <= ARB;
      burst_cnt          <= '0;
      bus.pipe_txvalid_o <= 1'b0;
      bus.pipe_txdata_o  <= '0;
    end else begin
      bus.pipe_txvalid_o <= tlp_take || dllp_take;
      if (tlp_take || dllp_take) begin
        bus.pipe_txdata_o <= tx_data_d;
      end
      case (state)
        ARB: begin
          if (dllp_gnt) begin
            if (!tlp_req) begin
              burst_cnt <= '0;
            end else if (burst_cnt != BURST_MAX) begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end else if (tlp_gnt) begin
            burst_cnt <= '0;
            if (!bus.tlp_last_i) begin
              state <= TLP_BUSY;
            end
          end
        end
        TLP_BUSY: begin
          // link state is ignored here so a started TLP always completes
          if (tlp_take && bus.tlp_last_i) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef DLL_TX_ARB_STATS_EN
  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      stat_tlp_beats_o <= '0;
      stat_dllp_cnt_o  <= '0;
      stat_starve_o    <= '0;
    end else begin
      if (tlp_take) begin
        stat_tlp_beats_o <= stat_tlp_beats_o + 32'd1;
      end
      if (dllp_take) begin
        stat_dllp_cnt_o <= stat_dllp_cnt_o + 32'd1;
      end
      if (dllp_gnt && tlp_req) begin
        stat_starve_o <= stat_starve_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Table-driven bench for dll_tx_arbiter with a scoreboard of accepted beats.
module tb_dll_tx_arbiter;
  import dll_pkg::*;

  localparam int W    = 256;
  localparam int MAXB = 4;

  typedef struct {
    logic       rst_n;
    logic [1:0] dlcm;
    logic       tv;
    logic       tl;
    logic       dv;
    logic       exp_tr;
    logic       exp_dr;
  } vec_t;

  logic sclk = 1'b0;
  logic srst_n = 1'b0;
  always #5 sclk = ~sclk;

  dll_tx_arbiter_if #(.PIPE_DATA_WIDTH(W)) bus ();

`ifdef DLL_TX_ARB_STATS_EN
  logic [31:0] stat_tlp_beats;
  logic [31:0] stat_dllp_cnt;
  logic [31:0] stat_starve;
  int exp_tlp_beats = 0;
  int exp_dllps     = 0;
`endif

  dll_tx_arbiter #(
    .PIPE_DATA_WIDTH(W),
    .MAX_DLLP_BURST (MAXB)
  ) dut (
    .sclk  (sclk),
    .srst_n(srst_n),
    .bus   (bus)
`ifdef DLL_TX_ARB_STATS_EN
    ,
    .stat_tlp_beats_o(stat_tlp_beats),
    .stat_dllp_cnt_o (stat_dllp_cnt),
    .stat_starve_o   (stat_starve)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] last_data = '0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [1:0] s, input logic tv, input logic tl,
                              input logic dv, input logic etr, input logic edr);
    vec_t v;
    v.rst_n = r; v.dlcm = s; v.tv = tv; v.tl = tl; v.dv = dv; v.exp_tr = etr; v.exp_dr = edr;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [W-1:0] td;
    logic [W-1:0] dd;
    logic         pushed;
    logic [W-1:0] exp;
    for (int k = 0; k < W / 32; k++) begin
      td[k*32 +: 32] = $urandom;
      dd[k*32 +: 32] = $urandom;
    end
    td[15:0] = 16'(idx);
    dd[15:0] = 16'(idx) | 16'h8000;
    @(negedge sclk);
    srst_n           = v.rst_n;
    bus.dlcm_state_i = v.dlcm;
    bus.tlp_valid_i  = v.tv;
    bus.tlp_last_i   = v.tl;
    bus.tlp_data_i   = td;
    bus.dllp_valid_i = v.dv;
    bus.dllp_data_i  = dd;
    #1;
    check($sformatf("step%0d tlp_ready", idx), W'(bus.tlp_ready_o), W'(v.exp_tr));
    check($sformatf("step%0d dllp_ready", idx), W'(bus.dllp_ready_o), W'(v.exp_dr));
    pushed = 1'b0;
    if (v.rst_n && v.tv && v.exp_tr) begin
      sb.push_back(td);
      pushed = 1'b1;
`ifdef DLL_TX_ARB_STATS_EN
      exp_tlp_beats++;
`endif
    end else if (v.rst_n && v.dv && v.exp_dr) begin
      sb.push_back(dd);
      pushed = 1'b1;
`ifdef DLL_TX_ARB_STATS_EN
      exp_dllps++;
`endif
    end
`ifdef DLL_TX_ARB_STATS_EN
    if (!v.rst_n) begin
      exp_tlp_beats = 0;
      exp_dllps     = 0;
    end
`endif
    @(posedge sclk);
    #1;
    if (!v.rst_n) last_data = '0;
    check($sformatf("step%0d txvalid", idx), W'(bus.pipe_txvalid_o), W'(pushed));
    if (pushed && sb.size() > 0) begin
      exp = sb.pop_front();
      last_data = exp;
    end
    check($sformatf("step%0d txdata", idx), bus.pipe_txdata_o, last_data);
  endtask

  initial begin
    bus.dlcm_state_i = 2'b00;
    bus.tlp_valid_i  = 1'b0;
    bus.tlp_last_i   = 1'b0;
    bus.tlp_data_i   = '0;
    bus.dllp_valid_i = 1'b0;
    bus.dllp_data_i  = '0;

    // reset and gating in inactive states
    vecs.push_back(mk(0, 2'b10, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 2'b11, 1, 1, 1, 0, 0));
    // DL_INIT: DLLPs only, no burst limit since TLP not allowed
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 2'b01, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 1, 1, 0, 1, 0));
    // burst limit: 4 DLLP then 1 TLP, twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 2'b10, 1, 1, 1, 0, 1));
      vecs.push_back(mk(1, 2'b10, 1, 1, 1, 1, 0));
    end
    // DLLP with no TLP waiting clears the burst count
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 0, 1, 1, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 1, 0));
    // idle cycle keeps the burst count
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b00, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 1, 0));
    // 3-beat TLP, DLLP raised mid-packet, sent right after last beat
    vecs.push_back(mk(1, 2'b10, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 1, 0, 1));
    // bubbles in TLP_BUSY with link drop; packet completes, then nothing
    vecs.push_back(mk(1, 2'b10, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 2'b00, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 2'b00, 1, 1, 1, 0, 0));
    // reset during beat 2 of a 4-beat TLP; ARB afterwards
    vecs.push_back(mk(1, 2'b10, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 2'b10, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b10, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 2'b10, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 2'b10, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 2'b10, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // continuous traffic: steady 4 DLLP / 1 TLP pattern
    for (int k = 0; k < 15; k++) begin
      apply(mk(1, 2'b10, 1, 1, 1, (k % 5) == 4, (k % 5) != 4), 1000 + k);
    end

    check("scoreboard_empty", W'(sb.size()), W'(0));

`ifdef DLL_TX_ARB_STATS_EN
    // fresh reset, then 10 TLP beats and 3 DLLPs
    apply(mk(0, 2'b00, 0, 0, 0, 0, 0), 2000);
    apply(mk(1, 2'b10, 0, 0, 1, 0, 1), 2001);
    for (int k = 0; k < 10; k++) apply(mk(1, 2'b10, 1, (k % 5) == 4, 0, 1, 0), 2002 + k);
    apply(mk(1, 2'b10, 0, 0, 1, 0, 1), 2012);
    apply(mk(1, 2'b10, 0, 0, 1, 0, 1), 2013);
    check("stat_tlp_beats", W'(stat_tlp_beats), W'(32'(exp_tlp_beats)));
    check("stat_dllp_cnt", W'(stat_dllp_cnt), W'(32'(exp_dllps)));
    check("stat_tlp_beats_10", W'(stat_tlp_beats), W'(32'd10));
    check("stat_dllp_cnt_3", W'(stat_dllp_cnt), W'(32'd3));
    check("stat_starve_0", W'(stat_starve), W'(32'd0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
